// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep two's-complement adder/subtractor.
// Each stage adds one CHUNK-bit slice using the carry registered by the
// previous stage; the upper operand slices ride along in skew registers and
// the finished lower result slices ride along until the last stage, where
// the full result and the CF/ZF/SF/OF flags are registered together.
// One global advance signal moves or holds the whole pipe (no bubble
// compression), so in_ready never depends on in_valid.
// Optional feature macro: PIPE_ADDSUB_SAT_EN adds in_sat, which clamps an
// overflowing result to the signed max/min value.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
`ifdef PIPE_ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cf,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             cf_reg;
  logic             zf_reg;
  logic             sf_reg;
  logic             of_reg;

  // The pipe moves when the output slot is empty or being drained.
  assign adv       = out_ready | ~out_valid_reg;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cf    = cf_reg;
  assign out_zf    = zf_reg;
  assign out_sf    = sf_reg;
  assign out_of    = of_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand bits not yet summed when the beat enters this stage.
      localparam int REM_W = WIDTH - gi * CHUNK;

      logic [REM_W-1:0] a_in;
      logic [REM_W-1:0] b_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK:0]   slice;
`ifdef PIPE_ADDSUB_SAT_EN
      logic             sat_in;
`endif

      if (gi == 0) begin : g_src
        // B is inverted once at entry; the +1 of the subtract enters as carry.
        assign a_in = in_a;
        assign b_in = in_b ^ {WIDTH{in_sub}};
        assign c_in = in_sub;
        assign v_in = in_valid & adv;
`ifdef PIPE_ADDSUB_SAT_EN
        assign sat_in = in_sat;
`endif
      end else begin : g_src
        assign a_in = g_stage[gi-1].g_mid.a_hi_reg;
        assign b_in = g_stage[gi-1].g_mid.b_hi_reg;
        assign c_in = g_stage[gi-1].g_mid.c_reg;
        assign v_in = g_stage[gi-1].g_mid.v_reg;
`ifdef PIPE_ADDSUB_SAT_EN
        assign sat_in = g_stage[gi-1].g_mid.sat_reg;
`endif
      end

      // This stage's slice; bit CHUNK is the carry into the next slice.
      assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, c_in};

      if (gi < STAGES - 1) begin : g_mid
        localparam int HI_W = REM_W - CHUNK;
        localparam int LO_W = (gi + 1) * CHUNK;

        logic [HI_W-1:0] a_hi_reg;
        logic [HI_W-1:0] b_hi_reg;
        logic [LO_W-1:0] s_lo_reg;
        logic [LO_W-1:0] s_lo_next;
        logic            c_reg;
        logic            v_reg;
`ifdef PIPE_ADDSUB_SAT_EN
        logic            sat_reg;
`endif

        if (gi == 0) begin : g_lo
          assign s_lo_next = slice[CHUNK-1:0];
        end else begin : g_lo
          assign s_lo_next = {slice[CHUNK-1:0], g_stage[gi-1].g_mid.s_lo_reg};
        end

        // Skew register: forward remaining operands, carry and finished slices.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            a_hi_reg <= '0;
            b_hi_reg <= '0;
            s_lo_reg <= '0;
            c_reg    <= 1'b0;
            v_reg    <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_reg  <= 1'b0;
`endif
          end else if (adv) begin
            a_hi_reg <= a_in[REM_W-1:CHUNK];
            b_hi_reg <= b_in[REM_W-1:CHUNK];
            s_lo_reg <= s_lo_next;
            c_reg    <= slice[CHUNK];
            v_reg    <= v_in;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_reg  <= sat_in;
`endif
          end
        end
      end else begin : g_last
        logic [WIDTH-1:0] raw_sum;
        logic [WIDTH-1:0] fin_sum;
        logic             ovf;

        if (gi == 0) begin : g_sum
          assign raw_sum = slice[CHUNK-1:0];
        end else begin : g_sum
          assign raw_sum = {slice[CHUNK-1:0], g_stage[gi-1].g_mid.s_lo_reg};
        end

        // Signed overflow: operands (with B already inverted) agree in sign
        // but the result does not.
        assign ovf = (a_in[CHUNK-1] == b_in[CHUNK-1]) &
                     (raw_sum[WIDTH-1] != a_in[CHUNK-1]);

`ifdef PIPE_ADDSUB_SAT_EN
        // Clamp toward the sign of the operands when saturation is requested.
        always_comb begin
          fin_sum = raw_sum;
          if (sat_in & ovf) begin
            fin_sum = a_in[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end
`else
        assign fin_sum = raw_sum;
`endif

        // Output register: result and flags move together, held under stall.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            cf_reg        <= 1'b0;
            zf_reg        <= 1'b0;
            sf_reg        <= 1'b0;
            of_reg        <= 1'b0;
          end else if (adv) begin
            out_valid_reg <= v_in;
            if (v_in) begin
              out_sum_reg <= fin_sum;
              cf_reg      <= slice[CHUNK];
              zf_reg      <= (fin_sum == '0);
              sf_reg      <= fin_sum[WIDTH-1];
              of_reg      <= ovf;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=64, STAGES=4).
// Directed vectors with constant expectations plus a randomized stream
// checked against an arithmetic reference model through a scoreboard queue.
module tb_pipelined_addsub;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cf;
  logic             out_zf;
  logic             out_sf;
  logic             out_of;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
`ifdef PIPE_ADDSUB_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cf    (out_cf),
    .out_zf    (out_zf),
    .out_sf    (out_sf),
    .out_of    (out_of)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cf;
    logic             zf;
    logic             sf;
    logic             of;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_no = 0;
  logic hold_pending = 1'b0;
  res_t held;
  logic last_ready;
  logic last_acc;

  // Reference: signed/unsigned arithmetic on widened values.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic sat);
    res_t r;
    logic signed [WIDTH+1:0] sa, sb, sr, smax, smin;
    logic [WIDTH:0] u;
    sa   = {{2{a[WIDTH-1]}}, a};
    sb   = {{2{b[WIDTH-1]}}, b};
    smax = {3'b000, {(WIDTH-1){1'b1}}};
    smin = {3'b111, {(WIDTH-1){1'b0}}};
    sr   = sub ? (sa - sb) : (sa + sb);
    u    = {1'b0, a} + {1'b0, b};
    r.cf  = sub ? (a >= b) : u[WIDTH];
    r.of  = (sr > smax) || (sr < smin);
    r.sum = sr[WIDTH-1:0];
`ifdef PIPE_ADDSUB_SAT_EN
    if (sat && r.of) r.sum = (sr > 0) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
`else
    if (sat && 1'b0) r.sum = '0;
`endif
    r.zf = (r.sum == '0);
    r.sf = r.sum[WIDTH-1];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_operand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(WIDTH-1){1'b0}}};
      3: v = {1'b0, {(WIDTH-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // One clock: sample outputs, score transfers, record acceptances, advance.
  task automatic cycle();
    res_t got;
    res_t e;
    #1;
    got = {out_sum, out_cf, out_zf, out_sf, out_of};
    if (hold_pending && out_valid) begin
      checks++;
      assert (got === held) else begin
        errors++;
        $error("FAIL hold got %h exp %h", got, held);
      end
    end
    hold_pending = out_valid & ~out_ready;
    held = got;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out got sum %h exp no beat", out_sum);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
          errors++;
          $error("FAIL result got %h exp %h", got, e);
        end
        $display("beat %0d sum=%h cf=%b zf=%b sf=%b of=%b", beat_no, out_sum,
                 out_cf, out_zf, out_sf, out_of);
        beat_no++;
      end
    end
    last_ready = in_ready;
    last_acc   = in_valid & in_ready;
    if (last_acc) exp_q.push_back(model(in_a, in_b, in_sub, in_sat));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic sub, input logic sat);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_sat = sat;
    for (int t = 0; t < 100 && !done; t++) begin
      cycle();
      done = last_acc;
    end
    in_valid = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL accept_timeout got 0 exp 1");
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) cycle();
    repeat (STAGES + 2) cycle();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL lost_beats got %0d pending exp 0", exp_q.size());
    end
  endtask

  // Lone beat on an empty pipe: latency and constant result check.
  task automatic single(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sub, input logic sat,
                        input logic [WIDTH-1:0] es, input logic [3:0] ef);
    int lat;
    out_ready = 1'b1;
    send(a, b, sub, sat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      cycle();
      lat++;
    end
    checks++;
    assert (lat == STAGES) else begin
      errors++;
      $error("FAIL %s_latency got %0d exp %0d", tag, lat, STAGES);
    end
    checks++;
    assert (out_sum === es) else begin
      errors++;
      $error("FAIL %s_sum got %h exp %h", tag, out_sum, es);
    end
    checks++;
    assert ({out_cf, out_zf, out_sf, out_of} === ef) else begin
      errors++;
      $error("FAIL %s_flags got %b exp %b", tag, {out_cf, out_zf, out_sf, out_of}, ef);
    end
    cycle();
  endtask

  initial begin
    int   sent;
    int   stalls;
    logic saw_first;
    logic saw_block;
    logic [WIDTH-1:0] bp_a [8];
    logic [WIDTH-1:0] bp_b [8];

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_sat = 1'b0; out_ready = 1'b1;

    // Reset state
    do_reset(2);
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++; $error("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    assert ({out_sum, out_cf, out_zf, out_sf, out_of} === {WIDTH'(0), 4'b0000}) else begin
      errors++; $error("FAIL reset_out got %h exp 0", out_sum);
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++; $error("FAIL reset_ready got %b exp 1", in_ready);
    end

    // Directed vectors; flags are {cf,zf,sf,of}
    single("add5_7", 64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 4'b0000);
    single("xslice", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 4'b0000);
    single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 4'b1100);
    single("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b1001);
    single("sub3_5", 64'd3, 64'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
    single("sub0_1", 64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
`ifdef PIPE_ADDSUB_SAT_EN
    single("sat_on", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b0001);
    single("sat_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1,
           64'h8000_0000_0000_0000, 4'b1011);
`endif
    single("sat_off", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 4'b0011);

    // Backpressure: 8 back-to-back beats, stall once the first result shows
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = {$urandom, $urandom};
      bp_b[i] = {$urandom, $urandom};
    end
    out_ready = 1'b1; sent = 0; stalls = 0; saw_first = 1'b0; saw_block = 1'b0;
    for (int g = 0; g < 200 && sent < 8; g++) begin
      in_valid = 1'b1; in_a = bp_a[sent]; in_b = bp_b[sent];
      in_sub = sent[0]; in_sat = 1'b0;
      if (out_valid && !saw_first) begin
        saw_first = 1'b1;
        out_ready = 1'b0;
      end
      if (!out_ready) stalls++;
      if (stalls > 6) out_ready = 1'b1;
      cycle();
      if (last_acc) sent++;
      if (!last_ready && !saw_block) begin
        saw_block = 1'b1;
        checks++;
        assert (exp_q.size() == STAGES) else begin
          errors++; $error("FAIL pipe_depth got %0d exp %0d", exp_q.size(), STAGES);
        end
      end
    end
    checks++;
    assert (saw_block) else begin
      errors++; $error("FAIL ready_drop got 0 exp 1");
    end
    drain();

    // Randomized stream with random valid and backpressure
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rnd_operand();
      in_b      = rnd_operand();
      in_sub    = 1'($urandom_range(0, 1));
      in_sat    = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    // Reset mid-flight: three beats in the pipe are discarded
    in_sat = 1'b0;
    out_ready = 1'b1;
    send(64'd11, 64'd22, 1'b0, 1'b0);
    send(64'd33, 64'd44, 1'b0, 1'b0);
    send(64'd55, 64'd66, 1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < STAGES + 2; i++) begin
      checks++;
      assert ({out_valid, out_sum, out_cf, out_zf, out_sf, out_of} === {1'b0, WIDTH'(0), 4'b0000})
      else begin
        errors++;
        $error("FAIL midreset_out got v=%b sum=%h exp v=0 sum=0", out_valid, out_sum);
      end
      cycle();
    end
    single("post_reset", 64'd100, 64'd1, 1'b1, 1'b0, 64'd99, 4'b1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
